// File: rtl/sio_master.sv
// Initiator for the SiTCP serial register link: sends command/address/data frames,
// clocks the slave until its start bit, then captures the 8-bit response.
module sio_master #(
   parameter int unsigned CLK_DIV     = 4,
   parameter int unsigned ADDR_BYTES  = 4,
   parameter int unsigned ACK_TIMEOUT = 1024
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ_WE,
   input  logic        REQ_RE,
   input  logic [31:0] REQ_ADDR,
   input  logic [7:0]  REQ_WD,
   output logic        BUSY,
   output logic        DONE,
   output logic [7:0]  RD_DATA,
   output logic        TIMEOUT_ERR,
   output logic        SCK,
   output logic        SCS,
   output logic        SO,
   input  logic        SI
);

   localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [5:0] NbRdLast = 6'(8 * ADDR_BYTES + 7);
   localparam logic [5:0] NbWrLast = 6'(8 * ADDR_BYTES + 15);

   typedef enum logic [2:0] {StIdle, StSetup, StShift, StWaitAck, StRecv, StEnd} state_e;

   state_e        state_q;
   logic [7:0]    div_q;
   logic [5:0]    bit_cnt_q;
   logic [TW-1:0] to_cnt_q;
   logic [47:0]   sr_q;
   logic [6:0]    rx_q;
   logic          rd_q;
   logic          busy_q, done_q, terr_q, sck_q, scs_q, so_q;
   logic [7:0]    rd_data_q;

   logic          tick;
   logic          accept;
   logic [7:0]    cmd;
   logic [31:0]   addr_al;
   logic [47:0]   frame;

   assign tick   = (div_q == 8'(CLK_DIV - 1));
   // The cycle carrying DONE is not an acceptance cycle.
   assign accept = (REQ_WE | REQ_RE) & ~done_q;

   always_comb begin
      cmd     = {1'b1, 1'b0, REQ_RE, 1'b0, 2'(ADDR_BYTES - 1), 2'b00};
      addr_al = REQ_ADDR << (32 - 8 * ADDR_BYTES);
      frame   = {cmd, addr_al, 8'h00};
      if (!REQ_RE) frame[39-8*ADDR_BYTES -: 8] = REQ_WD;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= StIdle;
         div_q     <= 8'd0;
         bit_cnt_q <= 6'd0;
         to_cnt_q  <= '0;
         sr_q      <= 48'd0;
         rx_q      <= 7'd0;
         rd_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         terr_q    <= 1'b0;
         sck_q     <= 1'b0;
         scs_q     <= 1'b0;
         so_q      <= 1'b0;
         rd_data_q <= 8'h00;
      end else begin
         done_q <= 1'b0;
         if (state_q != StIdle) div_q <= tick ? 8'd0 : div_q + 8'd1;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  rd_q      <= REQ_RE;
                  so_q      <= frame[47];
                  sr_q      <= {frame[46:0], 1'b0};
                  scs_q     <= 1'b1;
                  busy_q    <= 1'b1;
                  terr_q    <= 1'b0;
                  bit_cnt_q <= 6'd0;
                  state_q   <= StSetup;
               end
            end
            StSetup: begin
               if (tick) begin
                  sck_q   <= 1'b1;
                  state_q <= StShift;
               end
            end
            StShift: begin
               if (tick) begin
                  sck_q <= ~sck_q;
                  if (sck_q) begin
                     if (bit_cnt_q == (rd_q ? NbRdLast : NbWrLast)) begin
                        so_q      <= 1'b0;
                        bit_cnt_q <= 6'd0;
                        to_cnt_q  <= '0;
                        state_q   <= StWaitAck;
                     end else begin
                        so_q      <= sr_q[47];
                        sr_q      <= {sr_q[46:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q + 6'd1;
                     end
                  end
               end
            end
            StWaitAck: begin
               if (tick) begin
                  sck_q <= ~sck_q;
                  if (!sck_q) begin
                     to_cnt_q <= to_cnt_q + TW'(1);
                  end else if (SI) begin
                     state_q <= StRecv;
                  end else if (to_cnt_q == TW'(ACK_TIMEOUT)) begin
                     terr_q    <= 1'b1;
                     rd_data_q <= 8'hFF;
                     scs_q     <= 1'b0;
                     state_q   <= StEnd;
                  end
               end
            end
            StRecv: begin
               if (tick) begin
                  sck_q <= ~sck_q;
                  if (sck_q) begin
                     rx_q <= {rx_q[5:0], SI};
                     if (bit_cnt_q == 6'd7) begin
                        rd_data_q <= {rx_q, SI};
                        scs_q     <= 1'b0;
                        state_q   <= StEnd;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 6'd1;
                     end
                  end
               end
            end
            StEnd: begin
               // SCS stays low for one divider period before reporting completion.
               if (tick) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign BUSY        = busy_q;
   assign DONE        = done_q;
   assign RD_DATA     = rd_data_q;
   assign TIMEOUT_ERR = terr_q;
   assign SCK         = sck_q;
   assign SCS         = scs_q;
   assign SO          = so_q;

endmodule

// File: tb/tb_sio_master.sv
// Directed bench for sio_master: three parameterisations share one behavioural slave model.
module tb_sio_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  req_we = '0;
   logic [2:0]  req_re = '0;
   logic [31:0] req_addr = '0;
   logic [7:0]  req_wd = '0;
   logic        si = 1'b0;
   wire  [2:0]  busy, done, terr, sck, scs, so;
   wire  [7:0]  rd0, rd1, rd2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   sio_master #(.CLK_DIV(4), .ADDR_BYTES(1), .ACK_TIMEOUT(16)) u_d0 (
      .CLK(clk), .RST(rst), .REQ_WE(req_we[0]), .REQ_RE(req_re[0]), .REQ_ADDR(req_addr),
      .REQ_WD(req_wd), .BUSY(busy[0]), .DONE(done[0]), .RD_DATA(rd0), .TIMEOUT_ERR(terr[0]),
      .SCK(sck[0]), .SCS(scs[0]), .SO(so[0]), .SI(si));

   sio_master #(.CLK_DIV(4), .ADDR_BYTES(4), .ACK_TIMEOUT(1024)) u_d1 (
      .CLK(clk), .RST(rst), .REQ_WE(req_we[1]), .REQ_RE(req_re[1]), .REQ_ADDR(req_addr),
      .REQ_WD(req_wd), .BUSY(busy[1]), .DONE(done[1]), .RD_DATA(rd1), .TIMEOUT_ERR(terr[1]),
      .SCK(sck[1]), .SCS(scs[1]), .SO(so[1]), .SI(si));

   sio_master #(.CLK_DIV(1), .ADDR_BYTES(2), .ACK_TIMEOUT(16)) u_d2 (
      .CLK(clk), .RST(rst), .REQ_WE(req_we[2]), .REQ_RE(req_re[2]), .REQ_ADDR(req_addr),
      .REQ_WD(req_wd), .BUSY(busy[2]), .DONE(done[2]), .RD_DATA(rd2), .TIMEOUT_ERR(terr[2]),
      .SCK(sck[2]), .SCS(scs[2]), .SO(so[2]), .SI(si));

   // Slave model watches whichever instance is selected.
   int   sel = 0;
   logic m_sck, m_scs, m_so;
   assign m_sck = sck[sel];
   assign m_scs = scs[sel];
   assign m_so  = so[sel];

   logic        ack_en = 1'b1;
   int          ack_delay = 2;
   logic [7:0]  resp = 8'hFF;
   logic [47:0] cap;
   logic [7:0]  cmd;
   int frame_rises, wait_rises, nb, dbit, phase, frames, we_cnt, cyc, last_rise, period;
   logic scs_prev = 1'b0;
   logic sck_prev = 1'b0;

   initial begin
      frames = 0; we_cnt = 0; cyc = 0; last_rise = 0; period = 0; phase = 0;
      frame_rises = 0; wait_rises = 0; nb = 0; dbit = 0; cap = '0; cmd = '0;
   end

   always @(negedge clk) begin
      cyc++;
      if (!m_scs) begin
         phase = 0;
         si    = 1'b0;
      end else begin
         if (!scs_prev) begin
            frames++;
            cap = '0; frame_rises = 0; wait_rises = 0; nb = 48; phase = 1;
         end
         if (m_sck && !sck_prev) begin
            period    = cyc - last_rise;
            last_rise = cyc;
            case (phase)
               1: begin
                  cap = {cap[46:0], m_so};
                  frame_rises++;
                  if (frame_rises == 8) begin
                     cmd = cap[7:0];
                     nb  = 8 + 8 * (int'(cmd[3:2]) + 1) + (cmd[5] ? 0 : 8);
                  end
                  if (frame_rises == nb) begin
                     phase = 2;
                     if (!cmd[5]) we_cnt++;
                  end
               end
               2: begin
                  wait_rises++;
                  if (ack_en && wait_rises == ack_delay) begin
                     si = 1'b1; phase = 3; dbit = 0;
                  end
               end
               3: begin
                  if (dbit < 8) begin
                     si = resp[7-dbit];
                     dbit++;
                  end else begin
                     si = 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
      scs_prev = m_scs;
      sck_prev = m_sck;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic strobe(input int idx, input logic w, input logic r, input logic [31:0] a,
                         input logic [7:0] d);
      @(negedge clk);
      req_we[idx] = w; req_re[idx] = r; req_addr = a; req_wd = d;
      @(negedge clk);
      req_we = '0; req_re = '0;
   endtask

   task automatic wait_done(input int idx);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 5000 && !got; i++) begin
         @(negedge clk);
         if (done[idx]) got = 1'b1;
      end
      check("done_seen", 64'(got), 64'd1);
   endtask

   task automatic run(input int idx, input logic w, input logic r, input logic [31:0] a,
                      input logic [7:0] d);
      strobe(idx, w, r, a, d);
      wait_done(idx);
   endtask

   int f0, w0;
   logic seen;

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_terr", 64'(terr), 64'd0);
      check("rst_scs_sck_so", 64'({scs, sck, so}), 64'd0);
      check("rst_rd", 64'({rd0, rd1, rd2}), 64'd0);

      // Write, 1 address byte.
      sel = 0; ack_en = 1'b1; ack_delay = 2; resp = 8'hFF; w0 = we_cnt;
      run(0, 1'b1, 1'b0, 32'h0000_0012, 8'hA5);
      check("wr_frame", 64'(cap[23:0]), 64'h80_12A5);
      check("wr_rises", 64'(frame_rises), 64'd24);
      check("wr_regwe", 64'(we_cnt - w0), 64'd1);
      check("wr_rd", 64'(rd0), 64'hFF);
      check("wr_terr", 64'(terr[0]), 64'd0);
      check("wr_scs", 64'(scs[0]), 64'd0);
      @(negedge clk);
      check("done_pulse", 64'(done[0]), 64'd0);

      // Read, 4 address bytes, 5-edge ack delay.
      sel = 1; ack_delay = 5; resp = 8'h3C;
      run(1, 1'b0, 1'b1, 32'hDEAD_BEEF, 8'h00);
      check("rd4_frame", 64'(cap[39:0]), 64'hAC_DEAD_BEEF);
      check("rd4_rises", 64'(frame_rises), 64'd40);
      check("rd4_rd", 64'(rd1), 64'h3C);
      check("rd4_terr", 64'(terr[1]), 64'd0);

      // No acknowledge: timeout after 16 rising edges.
      sel = 0; ack_en = 1'b0;
      run(0, 1'b0, 1'b1, 32'h0000_0021, 8'h00);
      check("to_rises", 64'(wait_rises), 64'd16);
      check("to_terr", 64'(terr[0]), 64'd1);
      check("to_rd", 64'(rd0), 64'hFF);
      ack_en = 1'b1; ack_delay = 3; resp = 8'h77;
      run(0, 1'b0, 1'b1, 32'h0000_0055, 8'h00);
      check("to_clr_terr", 64'(terr[0]), 64'd0);
      check("to_clr_rd", 64'(rd0), 64'h77);

      // Strobe while busy is dropped.
      resp = 8'hFF; f0 = frames;
      strobe(0, 1'b1, 1'b0, 32'h0000_0011, 8'h22);
      repeat (20) @(negedge clk);
      strobe(0, 1'b1, 1'b0, 32'h0000_0033, 8'h44);
      wait_done(0);
      repeat (60) @(negedge clk);
      check("busy_frames", 64'(frames - f0), 64'd1);

      // Both strobes together: a read.
      resp = 8'h66; f0 = frames;
      run(0, 1'b1, 1'b1, 32'h0000_0055, 8'h99);
      check("both_cmd", 64'(cap[15:0]), 64'hA0_55);
      check("both_frames", 64'(frames - f0), 64'd1);
      check("both_rd", 64'(rd0), 64'h66);

      // Reset in the middle of the shift phase.
      resp = 8'hFF;
      strobe(0, 1'b1, 1'b0, 32'h0000_0012, 8'hA5);
      seen = 1'b0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         @(negedge clk);
         if (frame_rises >= 10) seen = 1'b1;
      end
      check("rst_mid_reach", 64'(seen), 64'd1);
      rst = 1'b1;
      #1;
      check("rst_mid_out", 64'({scs[0], sck[0], busy[0]}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      resp = 8'h5A;
      run(0, 1'b0, 1'b1, 32'h0000_0034, 8'h00);
      check("rst_mid_frame", 64'(cap[15:0]), 64'hA0_34);
      check("rst_mid_rd", 64'(rd0), 64'h5A);

      // CLK_DIV=1, 2 address bytes.
      sel = 2; ack_delay = 2; resp = 8'h81;
      run(2, 1'b0, 1'b1, 32'h0000_0102, 8'h00);
      check("div1_frame", 64'(cap[23:0]), 64'hA4_0102);
      check("div1_rd", 64'(rd2), 64'h81);
      check("div1_period", 64'(period), 64'd2);
      check("div1_terr", 64'(terr[2]), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
